ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single RAM port between `N_CACHE` per-core caches using round-robin ownership. The granted cache keeps the port for its whole 16-beat line fill or write-back. During an atomic write-back, every accepted beat is broadcast to the other caches through their `cache_atomic_i` snoop path so their copies stay coherent. The block sits between the cache array and the RAM model / memory controller at multicore top level.

## Interface
- `N_CACHE`, 4: number of requesting caches (2..8).
- `MAX_HOLD`, 64: maximum number of cycles one owner may keep the grant.
- `HOLD_W`, 7: counter width, at least clog2(`MAX_HOLD`+1).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `c_read`  in  N_CACHE  per-cache `ram_read`.
- `c_write`  in  N_CACHE  per-cache `ram_write`.
- `c_atomic`  in  N_CACHE  per-cache `cache_atomic_o`.
- `c_addr`  in  N_CACHE*`DATA_ADDR_W`  per-cache address; slice i belongs to cache i.
- `c_data_w`  in  N_CACHE*`DATA_W`  per-cache write data.
- `c_permit`  out  N_CACHE  one-hot grant (`arbiter_permit`).
- `c_wait`  out  N_CACHE  per-cache `ram_wait`.
- `c_data_r`  out  N_CACHE*`DATA_W`  per-cache `ram_data_r`.
- `c_atomic_i`  out  N_CACHE  per-cache snoop strobe (`cache_atomic_i`).
- `snoop_addr`  out  `DATA_ADDR_W`  address for the snoop update.
- `mem_read`, `mem_write`  out  1  RAM strobes.
- `mem_addr`  out  `DATA_ADDR_W`  RAM address.
- `mem_data_w`  out  `DATA_W`  RAM write data.
- `mem_wait`  in  1  RAM stall.
- `mem_data_r`  in  `DATA_W`  RAM read data.
- `hold_err`  out  1  sticky error flag: an owner exceeded `MAX_HOLD`.

## Operation
- Request vector: `req[i] = c_read[i] | c_write[i]`.
- FSM has three states: IDLE, OWN, TURN.
- IDLE → OWN when any bit of `req` is set.
  - Owner = first requesting index at or above `rr_ptr`, searching cyclically.
  - Register `owner` and set `c_permit[owner]`.
- OWN:
  - `mem_read`, `mem_write`, `mem_addr` and `mem_data_w` mux combinationally from `owner`.
  - `c_wait[owner] = mem_wait`.
  - All other caches see `c_wait = 1`.
- OWN → TURN when `req[owner]` falls, or when the hold counter reaches `MAX_HOLD`. The timeout case also sets `hold_err`.
- TURN lasts one cycle: all permits are 0 and the mem strobes are 0. `rr_ptr` becomes `owner+1`, wrapping from `N_CACHE-1` to 0. TURN → IDLE.
- Atomic broadcast: in OWN, when `c_write[owner] & c_atomic[owner] & !mem_wait`:
  - `c_atomic_i[j] = 1` for every j != owner.
  - `snoop_addr = c_addr[owner]`.
  - `c_data_r[j] = c_data_w[owner]`.
- At all other times, `c_data_r[j] = mem_data_r` and `c_atomic_i = 0`.
- `c_atomic_i[owner]` is never asserted.
- Both `c_read[owner]` and `c_write[owner]` high at once: `mem_write` takes priority and `mem_read` is forced to 0.
- Requests from non-owners are ignored until a later IDLE. Nothing is queued; the request level is re-sampled.

## Timing
- Reset values (asynchronous, immediate):
  - FSM in IDLE, `rr_ptr` = 0, `owner` = 0, hold counter = 0, `hold_err` = 0.
  - `c_permit` = 0, `c_wait` = all ones, `c_atomic_i` = 0.
  - `mem_read` = `mem_write` = 0, `mem_addr` = `mem_data_w` = 0, `snoop_addr` = 0.
- Reset asserted mid-burst: the grant and strobes drop in the same cycle. No partial beat is replayed.
- Grant latency: a request seen in IDLE at edge n gives `c_permit` high after edge n+1.
- Release: `req[owner]` falls at edge n, the block is in TURN after edge n+1, and a new grant appears no earlier than edge n+3.
- Hold counter:
  - Clears on entry to OWN.
  - Increments every OWN cycle.
  - Saturates at `MAX_HOLD`.
- Broadcast is combinational. It is valid in exactly the cycles where the owner's write beat is accepted by RAM (`!mem_wait`).
- `hold_err` clears only on reset.

## Structure
- Shared package/defines: reuse `DATA_W` and `DATA_ADDR_W`; add an FSM state encoding (IDLE=0, OWN=1, TURN=2) and `LINE_BEATS`=16.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: `req` and `rr_ptr`. Outputs: `idx` and `valid`. It is tested standalone.
- Everything else (FSM, muxes, broadcast, hold counter) lives in `ram_arbiter`.

## Test plan
- Single request: cache 2 read burst of 16 beats, `mem_wait` = 0 → `c_permit` = 4'b0100 one cycle after the request; 16 beats reach `c_data_r[2]`; then TURN; `rr_ptr` = 3.
- All four caches request at reset release → grant order 0,1,2,3,0. Each grant is separated by exactly one TURN cycle.
- Atomic write by cache 1, address 0x0000_1230, data 0xDEAD_BEEF, with `mem_wait` toggling every other cycle:
  - `c_atomic_i` = 4'b1101 only on accepted beats.
  - `snoop_addr` = 0x1230 and `c_data_r[0,2,3]` = 0xDEADBEEF on those beats.
- Owner never releases, with `MAX_HOLD` = 64 → forced TURN after 64 OWN cycles; `hold_err` = 1 and stays 1; the next requester is granted.
- Owner asserts read and write together → `mem_write` = 1, `mem_read` = 0.
- `reset_n` low at beat 7 of a burst → in the same cycle `c_permit` = 0, `mem_read` = 0, `c_wait` = 4'b1111; after release, arbitration restarts from cache 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared widths, line length and FSM encoding for the RAM port arbiter.
package ram_arbiter_pkg;
  localparam int DATA_W      = 32;
  localparam int DATA_ADDR_W = 32;
  localparam int LINE_BEATS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// Cache-side and RAM-side bus of the arbiter. The slave view belongs to the
// arbiter; the master view is the caches plus the RAM model.
interface ram_arbiter_if import ram_arbiter_pkg::*; #(parameter int N_CACHE = 4);
  logic [N_CACHE-1:0]                  c_read;
  logic [N_CACHE-1:0]                  c_write;
  logic [N_CACHE-1:0]                  c_atomic;
  logic [N_CACHE-1:0][DATA_ADDR_W-1:0] c_addr;
  logic [N_CACHE-1:0][DATA_W-1:0]      c_data_w;
  logic [N_CACHE-1:0]                  c_permit;
  logic [N_CACHE-1:0]                  c_wait;
  logic [N_CACHE-1:0][DATA_W-1:0]      c_data_r;
  logic [N_CACHE-1:0]                  c_atomic_i;
  logic [DATA_ADDR_W-1:0]              snoop_addr;
  logic                                mem_read;
  logic                                mem_write;
  logic [DATA_ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]                   mem_data_w;
  logic                                mem_wait;
  logic [DATA_W-1:0]                   mem_data_r;
  logic                                hold_err;

  modport slave (
    input  c_read, c_write, c_atomic, c_addr, c_data_w, mem_wait, mem_data_r,
    output c_permit, c_wait, c_data_r, c_atomic_i, snoop_addr,
           mem_read, mem_write, mem_addr, mem_data_w, hold_err
  );

  modport master (
    output c_read, c_write, c_atomic, c_addr, c_data_w, mem_wait, mem_data_r,
    input  c_permit, c_wait, c_data_r, c_atomic_i, snoop_addr,
           mem_read, mem_write, mem_addr, mem_data_w, hold_err
  );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// searching cyclically.
module rr_pick #(
  parameter int N_CACHE = 4,
  parameter int IDX_W   = $clog2(N_CACHE)
) (
  input  logic [N_CACHE-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);
  logic [IDX_W:0] cand;

  // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N_CACHE - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_CACHE)) cand = cand - (IDX_W + 1)'(N_CACHE);
      if (req[cand[IDX_W-1:0]]) begin
        idx   = cand[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single RAM port; the owner keeps it for a whole
// burst, and atomic write beats are broadcast to the other caches.
module ram_arbiter import ram_arbiter_pkg::*; #(
  parameter int N_CACHE  = 4,
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(N_CACHE);

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   owner, rr_ptr, pick_idx;
  logic               pick_valid;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               hold_err_q;
  logic [N_CACHE-1:0] req;
  logic               own_req, timeout, bcast;

  assign req     = bus.c_read | bus.c_write;
  assign own_req = req[owner];
  // Timeout fires in the MAX_HOLD-th OWN cycle, so the owner gets exactly MAX_HOLD cycles.
  assign timeout = (state == ST_OWN) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign bcast   = (state == ST_OWN) & bus.c_write[owner] & bus.c_atomic[owner] & ~bus.mem_wait;
  assign bus.hold_err = hold_err_q;

  rr_pick #(.N_CACHE(N_CACHE), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_valid) state_nxt = ST_OWN;
      ST_OWN:  if (!own_req || timeout) state_nxt = ST_TURN;
      ST_TURN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, owner, round-robin pointer, hold counter and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      hold_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_valid) begin
        owner    <= pick_idx;
        hold_cnt <= '0;
      end
      if (state == ST_OWN) begin
        if (hold_cnt != HOLD_W'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
        if (state_nxt == ST_TURN)
          rr_ptr <= (owner == IDX_W'(N_CACHE - 1)) ? '0 : owner + 1'b1;
        if (timeout && own_req) hold_err_q <= 1'b1;
      end
    end
  end

  // Bus muxing from the owner and the atomic snoop broadcast.
  always_comb begin
    bus.c_permit   = '0;
    bus.c_wait     = '1;
    bus.c_atomic_i = '0;
    bus.snoop_addr = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_data_w = '0;
    for (int j = 0; j < N_CACHE; j++) bus.c_data_r[j] = bus.mem_data_r;
    if (state == ST_OWN) begin
      bus.c_permit[owner] = 1'b1;
      bus.c_wait[owner]   = bus.mem_wait;
      bus.mem_write       = bus.c_write[owner];
      bus.mem_read        = bus.c_read[owner] & ~bus.c_write[owner];
      bus.mem_addr        = bus.c_addr[owner];
      bus.mem_data_w      = bus.c_data_w[owner];
      if (bcast) begin
        bus.snoop_addr = bus.c_addr[owner];
        for (int j = 0; j < N_CACHE; j++) begin
          if (IDX_W'(j) != owner) begin
            bus.c_atomic_i[j] = 1'b1;
            bus.c_data_r[j]   = bus.c_data_w[owner];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter with a behavioural reference model.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int NC       = 4;
  localparam int MAX_HOLD = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.N_CACHE(NC)) bus ();

  ram_arbiter #(.N_CACHE(NC), .MAX_HOLD(MAX_HOLD), .HOLD_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [3:0] pk_req;
  logic [1:0] pk_ptr, pk_idx;
  logic       pk_valid;
  rr_pick #(.N_CACHE(NC), .IDX_W(2)) u_pick_tb (
    .req(pk_req), .rr_ptr(pk_ptr), .idx(pk_idx), .valid(pk_valid)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 owned, 2 turnaround.
  int m_phase, m_owner, m_ptr, m_cnt;
  bit m_err;

  logic [3:0]       o_permit, o_wait, o_ai;
  logic             o_mr, o_mw, o_err, o_mwait;
  logic [31:0]      o_snoop, o_mdr;
  logic [3:0][31:0] o_dr;

  int   dut_grants[$];
  int   gaps[$];
  int   zero_run;
  bit   have_grant;
  logic [3:0] prev_permit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NC; k++) if (r[(p + k) % NC]) return (p + k) % NC;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic check_outputs();
    logic [3:0]  e_permit, e_wait, e_ai;
    logic        e_mr, e_mw;
    logic [31:0] e_addr, e_dw, e_snoop, e_dr;
    bit          own, bc;
    own = (m_phase == 1);
    e_permit = '0; e_wait = '1; e_ai = '0; e_mr = 0; e_mw = 0;
    e_addr = '0; e_dw = '0; e_snoop = '0; bc = 0;
    if (own) begin
      e_permit[m_owner] = 1'b1;
      e_wait[m_owner]   = bus.mem_wait;
      e_mw   = bus.c_write[m_owner];
      e_mr   = bus.c_read[m_owner] & ~bus.c_write[m_owner];
      e_addr = bus.c_addr[m_owner];
      e_dw   = bus.c_data_w[m_owner];
      bc = bus.c_write[m_owner] && bus.c_atomic[m_owner] && !bus.mem_wait;
      if (bc) begin
        e_ai    = 4'hF & ~(4'b0001 << m_owner);
        e_snoop = bus.c_addr[m_owner];
      end
    end
    chk("permit", 32'(bus.c_permit), 32'(e_permit));
    chk("wait", 32'(bus.c_wait), 32'(e_wait));
    chk("atomic_i", 32'(bus.c_atomic_i), 32'(e_ai));
    chk("mem_read", 32'(bus.mem_read), 32'(e_mr));
    chk("mem_write", 32'(bus.mem_write), 32'(e_mw));
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_data_w", bus.mem_data_w, e_dw);
    chk("snoop_addr", bus.snoop_addr, e_snoop);
    chk("hold_err", 32'(bus.hold_err), 32'(m_err));
    for (int j = 0; j < NC; j++) begin
      e_dr = (bc && j != m_owner) ? bus.c_data_w[m_owner] : bus.mem_data_r;
      chk($sformatf("data_r%0d", j), bus.c_data_r[j], e_dr);
    end
    o_permit = bus.c_permit; o_wait = bus.c_wait; o_ai = bus.c_atomic_i;
    o_mr = bus.mem_read; o_mw = bus.mem_write; o_err = bus.hold_err;
    o_snoop = bus.snoop_addr; o_dr = bus.c_data_r;
    o_mwait = bus.mem_wait; o_mdr = bus.mem_data_r;
    if (o_permit != 0 && prev_permit == 0) begin
      dut_grants.push_back(onehot_idx(o_permit));
      if (have_grant) gaps.push_back(zero_run);
      have_grant = 1;
      zero_run = 0;
    end
    if (o_permit == 0) zero_run++;
    prev_permit = o_permit;
  endtask

  task automatic model_update();
    logic [3:0] r;
    int n;
    bit to;
    r = bus.c_read | bus.c_write;
    if (!reset_n) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (r != 0) begin
           m_owner = pick(r, m_ptr);
           m_phase = 1;
           m_cnt = 0;
         end
      1: begin
           n  = m_cnt + 1;
           to = (n >= MAX_HOLD);
           if (!r[m_owner] || to) begin
             if (r[m_owner] && to) m_err = 1;
             m_phase = 2;
             m_ptr = (m_owner + 1) % NC;
           end
           m_cnt = (n > MAX_HOLD) ? MAX_HOLD : n;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    bus.mem_data_r = $urandom;
  endtask

  task automatic drop_all();
    bus.c_read = '0; bus.c_write = '0; bus.c_atomic = '0; bus.mem_wait = 1'b0;
    repeat (3) step();
  endtask

  int beats, own_cycles, cur, raise_idx;
  bit released;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.c_read = '0; bus.c_write = '0; bus.c_atomic = '0;
    bus.c_addr = '0; bus.c_data_w = '0; bus.mem_wait = 1'b0; bus.mem_data_r = '0;
    pk_req = '0; pk_ptr = '0;
    model_reset();
    zero_run = 0; have_grant = 0; prev_permit = '0;

    // Standalone picker, exhaustive over request and pointer.
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < NC; p++) begin
        pk_req = 4'(r); pk_ptr = 2'(p);
        #1;
        chk("pick_valid", 32'(pk_valid), 32'(pick(4'(r), p) >= 0));
        if (r != 0) chk("pick_idx", 32'(pk_idx), 32'(pick(4'(r), p)));
      end
    end

    // Reset state while reset_n is low.
    #2;
    chk("rst_permit", 32'(bus.c_permit), 32'h0);
    chk("rst_wait", 32'(bus.c_wait), 32'hF);
    chk("rst_atomic_i", 32'(bus.c_atomic_i), 32'h0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'h0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_snoop", bus.snoop_addr, 32'h0);
    chk("rst_hold_err", 32'(bus.hold_err), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single 16-beat read burst from cache 2.
    bus.c_read = 4'b0100;
    step();
    chk("grant_latency_idle", 32'(o_permit), 32'h0);
    step();
    chk("grant_latency", 32'(o_permit), 32'h4);
    beats = 0;
    if (o_permit == 4'b0100 && o_mr && !o_mwait) begin
      beats++;
      chk("burst_data", o_dr[2], o_mdr);
    end
    for (int s = 0; s < 40 && beats < LINE_BEATS; s++) begin
      step();
      if (o_permit == 4'b0100 && o_mr && !o_mwait) begin
        beats++;
        chk("burst_data", o_dr[2], o_mdr);
      end
    end
    chk("burst_beats", 32'(beats), 32'(LINE_BEATS));
    bus.c_read = '0;
    step();
    step();
    chk("turn_permit", 32'(o_permit), 32'h0);
    bus.c_read = 4'hF;
    step();
    step();
    chk("rr_after_2", 32'(o_permit), 32'h8);
    drop_all();

    // All four request from reset release: order 0,1,2,3,0.
    reset_n = 1'b0; model_reset();
    step(); step();
    reset_n = 1'b1;
    dut_grants.delete(); gaps.delete(); have_grant = 0; zero_run = 0;
    bus.c_read = 4'hF; released = 0; beats = 0; raise_idx = 0;
    for (int s = 0; s < 200 && dut_grants.size() < 5; s++) begin
      step();
      if (o_permit != 0) begin
        if (!released) begin
          beats++;
          if (beats == 3) begin
            cur = onehot_idx(o_permit);
            bus.c_read[cur] = 1'b0;
            raise_idx = cur; released = 1; beats = 0;
          end
        end
      end else if (released) begin
        bus.c_read[raise_idx] = 1'b1;
        released = 0;
      end
    end
    chk("grant_count", 32'(dut_grants.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < dut_grants.size()) chk($sformatf("grant_order%0d", i), 32'(dut_grants[i]), 32'(exp_order[i]));
    chk("gap_count", 32'(gaps.size()), 32'd4);
    foreach (gaps[i]) chk("grant_gap", 32'(gaps[i]), 32'd2);
    drop_all();

    // Atomic write-back from cache 1 with mem_wait toggling.
    for (int i = 0; i < NC; i++) begin
      bus.c_addr[i] = $urandom; bus.c_data_w[i] = $urandom;
    end
    bus.c_write[1] = 1'b1; bus.c_atomic[1] = 1'b1;
    bus.c_addr[1] = 32'h0000_1230; bus.c_data_w[1] = 32'hDEAD_BEEF;
    beats = 0;
    for (int s = 0; s < 80 && beats < LINE_BEATS; s++) begin
      bus.mem_wait = ~bus.mem_wait;
      step();
      if (o_permit == 4'b0010) begin
        if (!o_mwait) begin
          beats++;
          chk("atomic_ai", 32'(o_ai), 32'hD);
          chk("atomic_snoop", o_snoop, 32'h1230);
          chk("atomic_dr0", o_dr[0], 32'hDEAD_BEEF);
          chk("atomic_dr2", o_dr[2], 32'hDEAD_BEEF);
          chk("atomic_dr3", o_dr[3], 32'hDEAD_BEEF);
        end else begin
          chk("atomic_stall_ai", 32'(o_ai), 32'h0);
        end
      end
    end
    chk("atomic_beats", 32'(beats), 32'(LINE_BEATS));
    drop_all();

    // Owner never releases: forced turnaround after MAX_HOLD cycles.
    bus.c_read[2] = 1'b1;
    own_cycles = 0;
    for (int s = 0; s < 100; s++) begin
      step();
      if (o_permit == 4'b0100) begin
        own_cycles++;
        bus.c_read[3] = 1'b1;
      end else if (own_cycles > 0) break;
    end
    chk("hold_cycles", 32'(own_cycles), 32'(MAX_HOLD));
    chk("hold_err_set", 32'(o_err), 32'h1);
    for (int s = 0; s < 6; s++) begin
      step();
      if (o_permit != 0) break;
    end
    chk("timeout_next_grant", 32'(o_permit), 32'h8);
    drop_all();
    chk("hold_err_sticky", 32'(o_err), 32'h1);

    // Read and write together: write wins.
    bus.c_read[0] = 1'b1; bus.c_write[0] = 1'b1;
    for (int s = 0; s < 6; s++) begin
      step();
      if (o_permit == 4'b0001) break;
    end
    chk("rw_permit", 32'(o_permit), 32'h1);
    chk("rw_mem_write", 32'(o_mw), 32'h1);
    chk("rw_mem_read", 32'(o_mr), 32'h0);
    drop_all();

    // Randomized traffic against the model.
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(7) == 0) bus.c_read[i] = ~bus.c_read[i];
        if ($urandom_range(7) == 0) bus.c_write[i] = ~bus.c_write[i];
        bus.c_atomic[i] = 1'($urandom_range(1));
        bus.c_addr[i] = $urandom;
        bus.c_data_w[i] = $urandom;
      end
      bus.mem_wait = 1'($urandom_range(1));
      step();
    end
    drop_all();

    // Reset asserted at beat 7 of a burst.
    bus.c_read[1] = 1'b1;
    beats = 0;
    for (int s = 0; s < 30 && beats < 7; s++) begin
      step();
      if (o_permit == 4'b0010 && o_mr) beats++;
    end
    chk("pre_reset_beats", 32'(beats), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_permit", 32'(bus.c_permit), 32'h0);
    chk("mid_rst_mem_read", 32'(bus.mem_read), 32'h0);
    chk("mid_rst_wait", 32'(bus.c_wait), 32'hF);
    chk("mid_rst_hold_err", 32'(bus.hold_err), 32'h0);
    step(); step();
    reset_n = 1'b1;
    bus.c_read = 4'hF;
    for (int s = 0; s < 6; s++) begin
      step();
      if (o_permit != 0) break;
    end
    chk("restart_grant", 32'(o_permit), 32'h1);
    drop_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
